uart_mmio: RTL and testbench
============================

# uart_mmio

Memory-mapped I/O block between the core's execute/memory stage and the UART receiver/transmitter. Decodes loads and stores in the 0x8000_00xx window and buffers received and transmitted bytes in small FIFOs. This decouples core timing from the serial handshakes. Also holds the cycle and retired-instruction counters, and returns read data with the same one-cycle latency as the block RAMs so the writeback mux treats it like memory.

## Interface
Parameters:
- FIFO_DEPTH, 8: entries per FIFO; power of two, ≥2.
- IO_BASE, 32'h8000_0000: base of the MMIO window; bits [31:8] are decoded.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- req_valid  in  1  memory access in EX this cycle (already squashed on flush).
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data; only [7:0] is used.
- inst_retired  in  1  one-cycle pulse per retired instruction.
- rdata  out  32  registered load data, valid the cycle after the request.
- hit  out  1  combinational; req_valid and address inside the window.
- rx_data  in  8  byte from uart_receiver.
- rx_valid  in  1  receiver byte valid.
- rx_ready  out  1  FIFO accepts the byte (ready/valid).
- tx_data  out  8  byte to uart_transmitter.
- tx_valid  out  1  TX FIFO non-empty.
- tx_ready  in  1  transmitter can accept a byte.

## Operation
Address map (offset = req_addr[7:0]; other offsets read 0, writes ignored):
- 0x00 status, RO: bit0 = TX FIFO not full, bit1 = RX FIFO not empty, others 0.
- 0x04 RX data, RO: a load returns {24'b0, head byte} and pops it. If the FIFO is empty, the load returns 0 and nothing is popped.
- 0x08 TX data, WO: a store pushes req_wdata[7:0]. If the FIFO is full, the byte is silently dropped.
- 0x10 cycle counter, RO, 32-bit.
- 0x14 instruction counter, RO, 32-bit.
- 0x18 counter reset, WO: any store clears both counters.

RX side:
- Push when rx_valid && rx_ready.
- rx_ready = !rx_full.

TX side:
- tx_data = head byte.
- Pop when tx_valid && tx_ready.

Counters:
- Cycle counter increments every cycle.
- Instruction counter increments when inst_retired = 1.
- Both wrap modulo 2^32.
- Clear has priority over increment. The cycle after a 0x18 store, both counters read 0.

Side effects occur only when hit = 1. A request outside the window has no effect and leaves rdata = 0.

## Timing
Reset values:
- rdata = 0, tx_valid = 0, rx_ready = 1, both FIFOs empty, both counters = 0.
- A reset asserted mid-traffic discards all FIFO contents.

Latency:
- Load: address in cycle N, rdata valid in cycle N+1. rdata returns to 0 in any cycle without a load hit.
- Pops and pushes take effect at the edge ending cycle N.
- A byte pushed in cycle N gives status bit1 = 1 for a load issued in cycle N+1.

Counter reads:
- A counter load returns the value registered before the edge, i.e. the count at cycle N.

Simultaneous events:
- RX full, with a core pop and rx_valid in the same cycle: rx_ready stays 0, because it is based on full; the push is deferred one cycle.
- TX full, with a core store and a transmitter pop in the same cycle: the store is dropped, because the status full flag governs.
- Push and pop on the same non-full, non-empty FIFO in the same cycle: the count is unchanged and both take effect.
- A TX store to an empty FIFO raises tx_valid in cycle N+1. There is no fall-through.

Pointers:
- log2(FIFO_DEPTH)+1 bits wide, wrapping naturally.
- Full = MSBs differ and the other bits are equal.
- Empty = pointers equal.

## Structure
- Shared package/defines: offsets MMIO_STATUS, MMIO_RX, MMIO_TX, MMIO_CYC, MMIO_INST, MMIO_CRST, and IO_BASE default.
- One sub-module, sync_fifo (WIDTH, DEPTH):
  - Inputs: clk, rst, wr_en, din, rd_en.
  - Outputs: dout = head (combinational), full, empty.
  - Instantiated twice, for RX and TX.
- Top level holds the decoder, the counters and the rdata register.

## Test plan
- Reset, then idle for 5 cycles → rdata = 0, rx_ready = 1, tx_valid = 0. A load at 0x8000_0010 returns 5 (±1 depending on issue cycle; check exact against the model).
- Receiver pushes 0x41, 0x42 → status = 0x3. Two loads at 0x04 return 0x41 then 0x42. A third returns 0, and status = 0x1.
- Store 0x55 to 0x08 with tx_ready = 0 → tx_valid = 1 next cycle and tx_data = 0x55. With tx_ready = 1 for one cycle, tx_valid = 0 afterwards.
- Nine TX stores with tx_ready = 0 (depth 8) → status bit0 = 0 after the 8th. The ninth byte never appears; drain yields exactly 8 bytes in order.
- Eight RX bytes without reads → rx_ready = 0. One pop and a held rx_valid → the byte is accepted one cycle later and order is preserved.
- 3 inst_retired pulses, then a store to 0x18 concurrent with a pulse → instruction counter reads 0 next cycle, and reads 1 after one more pulse.

Source files
------------

// File: rtl/uart_mmio_pkg.sv
// Shared constants for the UART MMIO block: window base and register offsets.
package uart_mmio_pkg;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h8000_0000;

  localparam logic [7:0] MMIO_STATUS = 8'h00;
  localparam logic [7:0] MMIO_RX     = 8'h04;
  localparam logic [7:0] MMIO_TX     = 8'h08;
  localparam logic [7:0] MMIO_CYC    = 8'h10;
  localparam logic [7:0] MMIO_INST   = 8'h14;
  localparam logic [7:0] MMIO_CRST   = 8'h18;

  // Decoded view of one core access that landed in the window.
  typedef struct packed {
    logic       ld;
    logic       st;
    logic [7:0] off;
    logic [7:0] wdata;
  } mmio_req_t;

endpackage

// File: rtl/uart_mmio_sync_fifo.sv
// Small synchronous FIFO with a combinational head and wrap-bit pointers.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;

  // Extra MSB on each pointer separates full from empty when indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Pointer update; a reset drops whatever is queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full)  wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_mmio.sv
// MMIO decoder, RX/TX byte FIFOs, cycle/instret counters, one-cycle load data.
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] IO_BASE    = IO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        inst_retired,
  output logic [31:0] rdata,
  output logic        hit,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  mmio_req_t   req;
  logic        rx_full, rx_empty, tx_full, tx_empty;
  logic [7:0]  rx_head;
  logic        rx_pop, tx_push, cnt_clr;
  logic [31:0] cyc_cnt, inst_cnt, rd_next;
  logic        wdata_unused;

  assign wdata_unused = ^req_wdata[31:8];

  assign hit       = req_valid && (req_addr[31:8] == IO_BASE[31:8]);
  assign req.ld    = hit && !req_we;
  assign req.st    = hit &&  req_we;
  assign req.off   = req_addr[7:0];
  assign req.wdata = req_wdata[7:0];

  // Full/empty flags are pre-edge state, so a full TX drops a store even if
  // the transmitter pops the same cycle.
  assign rx_pop   = req.ld && (req.off == MMIO_RX) && !rx_empty;
  assign tx_push  = req.st && (req.off == MMIO_TX) && !tx_full;
  assign cnt_clr  = req.st && (req.off == MMIO_CRST);

  assign rx_ready = !rx_full;
  assign tx_valid = !tx_empty;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (rx_valid && rx_ready),
    .din   (rx_data),
    .rd_en (rx_pop),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (tx_push),
    .din   (req.wdata),
    .rd_en (tx_valid && tx_ready),
    .dout  (tx_data),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // Counters: clear wins over increment, both wrap at 2^32.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cyc_cnt  <= '0;
      inst_cnt <= '0;
    end else begin
      cyc_cnt  <= cyc_cnt + 32'd1;
      if (inst_retired) inst_cnt <= inst_cnt + 32'd1;
    end
  end

  // Load data mux; zero whenever this cycle is not a load hit.
  always_comb begin
    rd_next = '0;
    if (req.ld) begin
      case (req.off)
        MMIO_STATUS: rd_next = {30'd0, !rx_empty, !tx_full};
        MMIO_RX:     rd_next = rx_empty ? 32'd0 : {24'd0, rx_head};
        MMIO_CYC:    rd_next = cyc_cnt;
        MMIO_INST:   rd_next = inst_cnt;
        default:     rd_next = '0;
      endcase
    end
  end

  // Register load data to match block-RAM read latency.
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else     rdata <= rd_next;
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Scoreboard bench for uart_mmio: queue-based reference model, decoupled monitor.
module tb_uart_mmio;
  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, inst_retired = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [31:0] rdata;
  logic        hit, rx_ready, tx_valid;
  logic [7:0]  rx_data = '0, tx_data;
  logic        rx_valid = 1'b0, tx_ready = 1'b0;

  always #5 clk = ~clk;

  uart_mmio #(.FIFO_DEPTH(DEPTH), .IO_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .inst_retired(inst_retired),
    .rdata(rdata), .hit(hit), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  // Reference state: byte queues and plain integer counters.
  logic [7:0]  rxq[$];
  logic [7:0]  txq[$];
  logic [31:0] m_cyc = '0, m_inst = '0;
  logic [31:0] exp_q[$];
  int checks = 0, errors = 0;
  int dut_pops = 0;

  function automatic bit in_win(input logic [31:0] a);
    return a[31:8] == BASE[31:8];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: at every edge compute the next rdata from pre-edge state, then update.
  initial begin : model
    logic [31:0] e;
    logic        rxf, txf, rxe, txe, clr;
    logic [7:0]  off;
    forever begin
      @(posedge clk);
      e = '0;
      if (rst) begin
        rxq.delete(); txq.delete();
        m_cyc = '0; m_inst = '0;
      end else begin
        if (tx_valid && tx_ready) dut_pops++;
        rxf = (rxq.size() == DEPTH); rxe = (rxq.size() == 0);
        txf = (txq.size() == DEPTH); txe = (txq.size() == 0);
        off = req_addr[7:0];
        clr = 1'b0;
        if (!txe && tx_ready) void'(txq.pop_front());
        if (req_valid && in_win(req_addr)) begin
          if (!req_we) begin
            case (off)
              8'h00: e = {30'd0, !rxe, !txf};
              8'h04: if (!rxe) e = {24'd0, rxq.pop_front()};
              8'h10: e = m_cyc;
              8'h14: e = m_inst;
              default: e = '0;
            endcase
          end else begin
            if (off == 8'h08 && !txf) txq.push_back(req_wdata[7:0]);
            if (off == 8'h18) clr = 1'b1;
          end
        end
        if (rx_valid && !rxf) rxq.push_back(rx_data);
        m_cyc  = clr ? 32'd0 : m_cyc + 32'd1;
        m_inst = clr ? 32'd0 : m_inst + {31'd0, inst_retired};
      end
      exp_q.push_back(e);
    end
  end

  // Monitor: on the falling edge pop the expected load data and compare outputs.
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rdata", rdata, e);
        chk("tx_valid", {31'd0, tx_valid}, {31'd0, txq.size() != 0});
        if (txq.size() != 0) chk("tx_data", {24'd0, tx_data}, {24'd0, txq[0]});
        chk("rx_ready", {31'd0, rx_ready}, {31'd0, rxq.size() < DEPTH});
        chk("hit", {31'd0, hit}, {31'd0, req_valid && in_win(req_addr)});
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [7:0] off);
    req_valid = 1'b1; req_we = 1'b0; req_addr = BASE | {24'd0, off};
    tick();
    req_valid = 1'b0;
  endtask

  task automatic store(input logic [7:0] off, input logic [31:0] d);
    req_valid = 1'b1; req_we = 1'b1; req_addr = BASE | {24'd0, off}; req_wdata = d;
    tick();
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  logic [7:0] offs [7] = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h0c};

  initial begin : stim
    int pops0;
    tick(2);
    rst = 1'b0;

    // Idle, then read the cycle counter.
    tick(5);
    load(8'h10);

    // Two received bytes, three RX loads, status around them.
    rx_valid = 1'b1; rx_data = 8'h41; tick();
    rx_data = 8'h42; tick();
    rx_valid = 1'b0;
    load(8'h00);
    load(8'h04); load(8'h04); load(8'h04);
    load(8'h00);

    // Single TX byte, held then drained.
    tx_ready = 1'b0;
    store(8'h08, 32'hAAAA_AA55);
    tick();
    tx_ready = 1'b1; tick();
    tx_ready = 1'b0; tick();

    // Overfill TX: ninth byte dropped, drain gives exactly the first eight.
    for (int i = 0; i < 9; i++) begin
      store(8'h08, 32'h10 + i);
      load(8'h00);
    end
    pops0 = dut_pops;
    tx_ready = 1'b1; tick(12);
    tx_ready = 1'b0; tick();
    chk("tx_drain_count", dut_pops - pops0, 8);

    // Fill RX, then pop while a new byte is held on the receiver side.
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 8'h60 + 8'(i); tick();
    end
    rx_data = 8'h99; tick();
    load(8'h04);
    tick();
    rx_valid = 1'b0;
    for (int i = 0; i < 9; i++) load(8'h04);
    load(8'h00);

    // Instruction counter clear racing a retire pulse.
    for (int i = 0; i < 3; i++) begin
      inst_retired = 1'b1; tick(); inst_retired = 1'b0; tick();
    end
    load(8'h14);
    inst_retired = 1'b1; store(8'h18, 32'h0); inst_retired = 1'b0;
    load(8'h14);
    inst_retired = 1'b1; tick(); inst_retired = 1'b0;
    load(8'h14);
    load(8'h10);

    // Out-of-window accesses have no effect.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8000_0108; req_wdata = 32'h77; tick();
    req_we = 1'b0; req_addr = 32'h0000_0010; tick();
    req_valid = 1'b0; load(8'h00);

    // Randomized traffic with a reset in the middle.
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) begin
        rst = 1'b1; tick(); rst = 1'b0;
      end
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        7:       req_addr = $urandom;
        8:       req_addr = 32'h8000_0100 | {24'd0, offs[$urandom_range(0, 6)]};
        default: req_addr = BASE | {24'd0, offs[$urandom_range(0, 6)]};
      endcase
      req_wdata    = $urandom;
      rx_valid     = 1'($urandom_range(0, 1));
      rx_data      = 8'($urandom);
      tx_ready     = ($urandom_range(0, 3) == 0);
      inst_retired = 1'($urandom_range(0, 1));
      tick();
    end
    req_valid = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0; inst_retired = 1'b0;
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
